// File: rtl/gstdmasnd_fifo_if.sv
// DMA-sound buffer bus: MCU load strobe, playback control and PCM/status outputs.
interface gstdmasnd_fifo_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          sload_n;
  logic [15:0]   mdin;
  logic          flush;
  logic [1:0]    mode;
  logic          sample_en;
  logic          sreq;
  logic [LW-1:0] level;
  logic [15:0]   audio_left;
  logic [15:0]   audio_right;
  logic          underrun;
  logic          overrun;

  modport master (
    output sload_n, mdin, flush, mode, sample_en,
    input  sreq, level, audio_left, audio_right, underrun, overrun
  );

  modport slave (
    input  sload_n, mdin, flush, mode, sample_en,
    output sreq, level, audio_left, audio_right, underrun, overrun
  );
endinterface

// File: rtl/gstdmasnd_fifo.sv
// DMA-sound sample FIFO: captures MCU-strobed words, requests refills and
// unpacks words into left/right PCM samples on each playback tick.
module gstdmasnd_fifo #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned REQ_LEVEL = 4
) (
  input  logic               clk32,
  input  logic               reset,
  gstdmasnd_fifo_if.slave    bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic {PH0 = 1'b0, PH1 = 1'b1} phase_t;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q, level_next;
  phase_t        phase, phase_next;
  logic          sload_d;
  logic [15:0]   left_q, right_q, left_next, right_next;
  logic          sreq_q, under_q, over_q;
  logic          push, full, push_ok, under_set, over_set, clr;
  logic [1:0]    pop_cnt;
  logic [15:0]   word0, word1;

  assign clr   = reset | bus.flush;
  assign push  = ~bus.sload_n & sload_d;
  assign full  = (level_q == LW'(DEPTH));
  assign word0 = mem[rd_ptr];
  assign word1 = mem[rd_ptr + AW'(1)];

  // Playback phase register
  always_ff @(posedge clk32) begin
    if (clr) phase <= PH0;
    else     phase <= phase_next;
  end

  // Playback next-state, sample unpacking and pop decision
  always_comb begin
    phase_next = phase;
    left_next  = left_q;
    right_next = right_q;
    pop_cnt    = 2'd0;
    under_set  = 1'b0;
    if (bus.sample_en) begin
      if (phase == PH1) begin
        // Second half of a mono frame always completes as mono
        if (level_q >= LW'(1)) begin
          left_next  = {word0[7:0], 8'h00};
          right_next = {word0[7:0], 8'h00};
          pop_cnt    = 2'd1;
          phase_next = PH0;
        end else begin
          under_set = 1'b1;
        end
      end else begin
        case (bus.mode)
          2'b01: begin
            if (level_q >= LW'(1)) begin
              left_next  = {word0[15:8], 8'h00};
              right_next = {word0[15:8], 8'h00};
              phase_next = PH1;
            end else begin
              under_set = 1'b1;
            end
          end
          2'b10: begin
            if (level_q >= LW'(2)) begin
              left_next  = word0;
              right_next = word1;
              pop_cnt    = 2'd2;
            end else begin
              under_set = 1'b1;
            end
          end
          default: begin
            if (level_q >= LW'(1)) begin
              left_next  = {word0[15:8], 8'h00};
              right_next = {word0[7:0], 8'h00};
              pop_cnt    = 2'd1;
            end else begin
              under_set = 1'b1;
            end
          end
        endcase
      end
    end
    push_ok    = push & (~full | (pop_cnt != 2'd0));
    over_set   = push & ~push_ok;
    level_next = level_q + LW'(push_ok) - LW'(pop_cnt);
  end

  // Load strobe edge detector runs through reset so the first low is seen as an edge
  always_ff @(posedge clk32) begin
    sload_d <= bus.sload_n;
  end

  always_ff @(posedge clk32) begin
    if (!clr && push_ok) mem[wr_ptr] <= bus.mdin;
  end

  always_ff @(posedge clk32) begin
    if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      left_q  <= '0;
      right_q <= '0;
      sreq_q  <= 1'b0;
      under_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= rd_ptr + AW'(pop_cnt);
      level_q <= level_next;
      left_q  <= left_next;
      right_q <= right_next;
      sreq_q  <= (level_next <= LW'(REQ_LEVEL));
      under_q <= under_q | under_set;
      over_q  <= over_q | over_set;
    end
  end

  assign bus.sreq        = sreq_q;
  assign bus.level       = level_q;
  assign bus.audio_left  = left_q;
  assign bus.audio_right = right_q;
  assign bus.underrun    = under_q;
  assign bus.overrun     = over_q;
endmodule
